// File: rtl/rop3_mode_recover_pkg.sv
// Shared types and constants for the ROP3 mode recovery monitor (package rop3_pkg).
// Optional timeout feature is enabled by defining ROP3_REC_TIMEOUT_EN.
package rop3_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2,
        ERROR   = 2'd3
    } rop3_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CONFLICT = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    localparam int         MT_W      = 3;
    localparam logic [7:0] FULL_MASK = 8'hFF;

endpackage

// File: rtl/rop3_mode_recover_if.sv
// Sample bus carrying observed (P, S, D, Result) tuples into the recovery monitor.
// in_valid qualifies one sample per cycle; there is no ready, the monitor accepts every cycle.
interface rop3_mode_recover_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic [N-1:0] P;
    logic [N-1:0] S;
    logic [N-1:0] D;
    logic [N-1:0] Result;

    modport master (output in_valid, P, S, D, Result);
    modport slave  (input  in_valid, P, S, D, Result);
endinterface

// File: rtl/rop3_minterm_scatter.sv
// Combinational scatter of one N-bit sample into per-minterm hit/value vectors,
// flagging bits that land on the same minterm with different results.
module rop3_minterm_scatter
    import rop3_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] p,
    input  logic [N-1:0] s,
    input  logic [N-1:0] d,
    input  logic [N-1:0] result,
    output logic [7:0]   hit,
    output logic [7:0]   val,
    output logic         intra_conflict
);

    logic [MT_W-1:0] k;

    always_comb begin
        hit            = '0;
        val            = '0;
        intra_conflict = 1'b0;
        k              = '0;
        for (int i = 0; i < N; i++) begin
            k = {p[i], s[i], d[i]};
            if (hit[k] && (val[k] != result[i])) begin
                intra_conflict = 1'b1;
            end
            hit[k] = 1'b1;
            val[k] = result[i];
        end
    end

endmodule

// File: rtl/rop3_mode_recover.sv
// Reconstructs the 8-bit ROP3 mode from registered (P, S, D, Result) samples.
// Define ROP3_REC_TIMEOUT_EN to abort collection after TIMEOUT non-contributing samples.
module rop3_mode_recover
    import rop3_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    rop3_mode_recover_if.slave   smp,
    output logic [7:0]           mode,
    output logic [7:0]           known_mask,
    output logic                 mode_valid,
    output logic [1:0]           err,
    output logic                 busy,
    output rop3_state_e          state
);

    logic         s1_valid;
    logic [N-1:0] s1_p, s1_s, s1_d, s1_r;

    logic [7:0] hit, val;
    logic       intra_conflict;
    logic       conflict;
    logic       contrib;

    rop3_state_e state_next;
    logic [7:0]  mode_next;
    logic [7:0]  mask_next;
    logic [1:0]  err_next;

    // Stage 1: every input is registered; start drops whatever would have entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_s     <= '0;
            s1_d     <= '0;
            s1_r     <= '0;
        end else begin
            s1_valid <= smp.in_valid && !start;
            s1_p     <= smp.P;
            s1_s     <= smp.S;
            s1_d     <= smp.D;
            s1_r     <= smp.Result;
        end
    end

    rop3_minterm_scatter #(.N(N)) u_scatter (
        .p              (s1_p),
        .s              (s1_s),
        .d              (s1_d),
        .result         (s1_r),
        .hit            (hit),
        .val            (val),
        .intra_conflict (intra_conflict)
    );

    assign conflict = intra_conflict || ((hit & known_mask & (val ^ mode)) != 8'h00);
    assign contrib  = (hit & ~known_mask) != 8'h00;

`ifdef ROP3_REC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt, to_cnt_next;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_comb begin
        state_next = state;
        mode_next  = mode;
        mask_next  = known_mask;
        err_next   = err;
`ifdef ROP3_REC_TIMEOUT_EN
        to_cnt_next = to_cnt;
`endif
        if (start) begin
            state_next = COLLECT;
            mode_next  = 8'h00;
            mask_next  = 8'h00;
            err_next   = ERR_NONE;
`ifdef ROP3_REC_TIMEOUT_EN
            to_cnt_next = '0;
`endif
        end else if (s1_valid && (state == COLLECT || state == DONE)) begin
            // Conflict outranks both completion and timeout.
            if (conflict) begin
                state_next = ERROR;
                err_next   = ERR_CONFLICT;
            end else begin
                mode_next = mode | (hit & val);
                mask_next = known_mask | hit;
                if (state == COLLECT) begin
                    if (mask_next == FULL_MASK) begin
                        state_next = DONE;
                    end
`ifdef ROP3_REC_TIMEOUT_EN
                    else if (!contrib) begin
                        if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
                            state_next  = ERROR;
                            err_next    = ERR_TIMEOUT;
                            to_cnt_next = CNT_W'(TIMEOUT);
                        end else begin
                            to_cnt_next = to_cnt + 1'b1;
                        end
                    end else begin
                        to_cnt_next = '0;
                    end
`endif
                end
            end
        end
    end

`ifndef ROP3_REC_TIMEOUT_EN
    logic unused_contrib;
    assign unused_contrib = contrib;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode       <= 8'h00;
            known_mask <= 8'h00;
            err        <= ERR_NONE;
            mode_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            mode       <= mode_next;
            known_mask <= mask_next;
            err        <= err_next;
            mode_valid <= (state_next == DONE);
            busy       <= (state_next == COLLECT);
        end
    end

`ifdef ROP3_REC_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_rop3_mode_recover.sv
// Directed and randomized check of rop3_mode_recover against a truth-table model.
module tb_rop3_mode_recover;
    import rop3_pkg::*;

    localparam int N  = 4;
    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  mode, known_mask;
    logic        mode_valid, busy;
    logic [1:0]  err;
    rop3_state_e dut_state;

    rop3_mode_recover_if #(.N(N)) smp_if ();

    rop3_mode_recover #(.N(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .smp        (smp_if.slave),
        .mode       (mode),
        .known_mask (known_mask),
        .mode_valid (mode_valid),
        .err        (err),
        .busy       (busy),
        .state      (dut_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: a truth table of learnt minterms plus a phase word
    bit       m_known[8];
    bit       m_tt[8];
    int       m_phase;     // 0 idle, 1 collecting, 2 done, 3 error
    int       m_err;
    int       m_idle_cnt;
    bit       pv;
    bit [3:0] pp, ps, pd, pr;

    logic [19:0] exp_q[$];

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_known[k] = 1'b0;
            m_tt[k]    = 1'b0;
        end
        m_phase    = 0;
        m_err      = 0;
        m_idle_cnt = 0;
        pv         = 1'b0;
    endtask

    task automatic model_apply(input bit [3:0] p, input bit [3:0] s,
                               input bit [3:0] d, input bit [3:0] r);
        bit seen[8];
        bit sval[8];
        bit conf;
        bit fresh;
        bit all;
        int k;
        conf  = 1'b0;
        fresh = 1'b0;
        for (int j = 0; j < 8; j++) begin
            seen[j] = 1'b0;
            sval[j] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            k = p[i] * 4 + s[i] * 2 + d[i];
            if (seen[k] && sval[k] != r[i]) conf = 1'b1;
            if (m_known[k] && m_tt[k] != r[i]) conf = 1'b1;
            seen[k] = 1'b1;
            sval[k] = r[i];
        end
        if (conf) begin
            m_phase = 3;
            m_err   = 1;
            return;
        end
        for (int j = 0; j < 8; j++) begin
            if (seen[j]) begin
                if (!m_known[j]) fresh = 1'b1;
                m_known[j] = 1'b1;
                m_tt[j]    = sval[j];
            end
        end
        if (m_phase == 1) begin
            all = 1'b1;
            for (int j = 0; j < 8; j++) if (!m_known[j]) all = 1'b0;
            if (all) m_phase = 2;
`ifdef ROP3_REC_TIMEOUT_EN
            else if (!fresh) begin
                m_idle_cnt++;
                if (m_idle_cnt == TO) begin
                    m_phase = 3;
                    m_err   = 2;
                end
            end else m_idle_cnt = 0;
`endif
        end
    endtask

    function automatic logic [19:0] model_outputs();
        logic [7:0] em, ek;
        for (int j = 0; j < 8; j++) begin
            ek[j] = m_known[j];
            em[j] = m_known[j] & m_tt[j];
        end
        return {em, ek, 1'(m_phase == 2), 2'(m_err), 1'(m_phase == 1)};
    endfunction

    task automatic model_edge(input bit st, input bit v, input bit [3:0] p,
                              input bit [3:0] s, input bit [3:0] d, input bit [3:0] r);
        if (st) begin
            model_reset();
            m_phase = 1;
        end else begin
            if (pv && (m_phase == 1 || m_phase == 2)) model_apply(pp, ps, pd, pr);
            pv = v;
            pp = p; ps = s; pd = d; pr = r;
        end
        exp_q.push_back(model_outputs());
    endtask

    // scoreboard
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [19:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_noexp"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_mode"},  32'(mode),       32'(e[19:12]));
        chk({tag, "_mask"},  32'(known_mask), 32'(e[11:4]));
        chk({tag, "_mval"},  32'(mode_valid), 32'(e[3]));
        chk({tag, "_err"},   32'(err),        32'(e[2:1]));
        chk({tag, "_busy"},  32'(busy),       32'(e[0]));
    endtask

    // driver
    task automatic step(input string tag, input bit st, input bit v, input bit [3:0] p,
                        input bit [3:0] s, input bit [3:0] d, input bit [3:0] r);
        @(negedge clk);
        start            = st;
        smp_if.in_valid  = v;
        smp_if.P         = p;
        smp_if.S         = s;
        smp_if.D         = d;
        smp_if.Result    = r;
        @(posedge clk);
        model_edge(st, v, p, s, d, r);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        smp_if.in_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] hidden;
    bit [3:0]   rp, rs, rd, rr;

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        smp_if.in_valid = 1'b0;
        smp_if.P = '0; smp_if.S = '0; smp_if.D = '0; smp_if.Result = '0;

        // reset state
        do_reset();
        #1;
        exp_q.push_back(model_outputs());
        check_outputs("reset");
        chk("reset_state", 32'(dut_state), 32'(IDLE));

        // samples are ignored while idle
        step("idle_s1", 0, 1, 4'b0000, 4'b0011, 4'b0101, 4'b0011);
        idle("idle_gap");
        chk("idle_mask", 32'(known_mask), 32'h0);

        // SRCCOPY recovery
        step("cp_start", 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        step("cp_s1", 0, 1, 4'b0000, 4'b0011, 4'b0101, 4'b0011);
        step("cp_s2", 0, 1, 4'b1111, 4'b0011, 4'b0101, 4'b0011);
        chk("cp_mask_half", 32'(known_mask), 32'h0F);
        idle("cp_gap");
        chk("cp_mode", 32'(mode), 32'hCC);
        chk("cp_mask", 32'(known_mask), 32'hFF);
        chk("cp_valid", 32'(mode_valid), 32'h1);
        // DONE still checks consistent samples without disturbing the result
        step("cp_recheck", 0, 1, 4'b1010, 4'b0110, 4'b0011, 4'b0110);
        idle("cp_recheck_gap");
        chk("cp_done_state", 32'(dut_state), 32'(DONE));

        // cross-sample conflict
        step("xc_start", 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        step("xc_s1", 0, 1, 4'b0000, 4'b0011, 4'b0101, 4'b0011);
        step("xc_bad", 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        idle("xc_gap");
        chk("xc_err", 32'(err), 32'h1);
        chk("xc_state", 32'(dut_state), 32'(ERROR));
        chk("xc_mode", 32'(mode), 32'h0C);
        chk("xc_mask", 32'(known_mask), 32'h0F);

        // intra-sample conflict
        step("ic_start", 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        step("ic_bad", 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        idle("ic_gap");
        chk("ic_err", 32'(err), 32'h1);
        chk("ic_mask", 32'(known_mask), 32'h0);

        // start collides with a sample; also start discards a sample already in stage 1
        step("sc_start", 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        step("sc_pre", 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        step("sc_restart", 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        step("sc_s1", 0, 1, 4'b0000, 4'b0011, 4'b0101, 4'b0011);
        step("sc_s2", 0, 1, 4'b1111, 4'b0011, 4'b0101, 4'b0011);
        idle("sc_gap");
        chk("sc_mode", 32'(mode), 32'hCC);
        chk("sc_err", 32'(err), 32'h0);

        // timeout on repeated non-contributing samples
        step("to_start", 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) step("to_s1", 0, 1, 4'b0000, 4'b0011, 4'b0101, 4'b0011);
        idle("to_gap");
`ifdef ROP3_REC_TIMEOUT_EN
        chk("to_err", 32'(err), 32'h2);
        chk("to_state", 32'(dut_state), 32'(ERROR));
`else
        chk("to_err", 32'(err), 32'h0);
        chk("to_state", 32'(dut_state), 32'(COLLECT));
`endif

        // asynchronous reset mid-collection
        step("rs_start", 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        step("rs_s1", 0, 1, 4'b0000, 4'b0011, 4'b0101, 4'b0011);
        idle("rs_gap");
        chk("rs_mask_before", 32'(known_mask), 32'h0F);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(model_outputs());
        check_outputs("rs_async");
        chk("rs_state", 32'(dut_state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        step("rs_ign1", 0, 1, 4'b1111, 4'b0011, 4'b0101, 4'b0011);
        idle("rs_ign2");
        chk("rs_ign_mask", 32'(known_mask), 32'h0);

        // randomized streams derived from a hidden mode, with occasional noise and restarts
        hidden = 8'($urandom);
        step("rnd_start", 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int c = 0; c < 400; c++) begin
            bit st, v;
            st = ($urandom_range(0, 99) < 3);
            v  = ($urandom_range(0, 99) < 75);
            if (st) hidden = 8'($urandom);
            rp = 4'($urandom); rs = 4'($urandom); rd = 4'($urandom);
            for (int i = 0; i < N; i++) rr[i] = hidden[rp[i] * 4 + rs[i] * 2 + rd[i]];
            if ($urandom_range(0, 99) < 5) rr = 4'($urandom);
            step("rnd", st, v, rp, rs, rd, rr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
